// File: rtl/sha3_pkg.sv
// Shared types for the SHA-3 feeder: output-size encodings, sequencer states,
// the FIFO entry layout and the digest length per size.
package sha3_pkg;

    typedef enum logic [1:0] {
        SIZE_512 = 2'd0,
        SIZE_384 = 2'd1,
        SIZE_256 = 2'd2,
        SIZE_224 = 2'd3
    } out_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_FEED,
        ST_PAD,
        ST_WAIT,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic        last;
        logic [2:0]  bytes;
        logic [31:0] data;
    } fifo_entry_t;

    localparam int unsigned FIFO_W      = $bits(fifo_entry_t);
    localparam int unsigned DIGEST_BITS = 512;

    function automatic logic [4:0] digest_words(input out_size_e sz);
        case (sz)
            SIZE_512: return 5'd16;
            SIZE_384: return 5'd12;
            SIZE_256: return 5'd8;
            default:  return 5'd7;
        endcase
    endfunction

endpackage

// File: rtl/sha3_feeder_if.sv
// Bus bundle between the feeder and its environment (message writer, keccak
// core and digest reader). The feeder takes the slave view.
interface sha3_feeder_if;
    logic         start;
    logic [1:0]   out_size_in;
    logic         wr_valid;
    logic         wr_ready;
    logic [31:0]  wr_data;
    logic         wr_last;
    logic [2:0]   wr_bytes;
    logic         k_reset;
    logic [31:0]  k_in;
    logic         k_in_ready;
    logic         k_is_last;
    logic [1:0]   k_byte_num;
    logic [1:0]   k_out_size;
    logic         k_buffer_full;
    logic [511:0] k_out;
    logic         k_out_ready;
    logic         busy;
    logic         done;
    logic [3:0]   rd_idx;
    logic [31:0]  rd_data;

    modport master (
        output start, out_size_in, wr_valid, wr_data, wr_last, wr_bytes,
               k_buffer_full, k_out, k_out_ready, rd_idx,
        input  wr_ready, k_reset, k_in, k_in_ready, k_is_last, k_byte_num,
               k_out_size, busy, done, rd_data
    );

    modport slave (
        input  start, out_size_in, wr_valid, wr_data, wr_last, wr_bytes,
               k_buffer_full, k_out, k_out_ready, rd_idx,
        output wr_ready, k_reset, k_in, k_in_ready, k_is_last, k_byte_num,
               k_out_size, busy, done, rd_data
    );
endinterface

// File: rtl/sha3_fifo.sv
// Synchronous FIFO with a fall-through head (rdata_o shows the oldest entry)
// and a flush that empties it in one cycle.
module sha3_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o)  wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            if (pop_i && !empty_o)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];
endmodule

// File: rtl/sha3_feeder.sv
// Sequencer in front of the keccak core: clears it, streams buffered message
// words with the trailing empty word when needed, and latches the digest.
module sha3_feeder
    import sha3_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CLR_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    sha3_feeder_if.slave bus
);
    localparam int CNT_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    state_e           state_q;
    logic [CNT_W-1:0] clr_cnt_q;
    logic             k_reset_q;
    logic [31:0]      k_in_q;
    logic             k_in_ready_q;
    logic             k_is_last_q;
    logic [1:0]       k_byte_num_q;
    logic             pad_pend_q;
    logic             last_acc_q;
    logic             done_q;
    out_size_e        out_size_q;
    logic [511:0]     digest_q;

    fifo_entry_t      head, wr_entry;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
    logic             xfer, final_held, wr_ready;
    logic [15:0][31:0] digest_view;

    assign xfer       = k_in_ready_q && !bus.k_buffer_full;
    // Once the message's final word sits in the output register nothing may follow it.
    assign final_held = k_in_ready_q && (k_is_last_q || pad_pend_q);
    assign wr_ready   = (state_q == ST_FEED) && !fifo_full && !last_acc_q;
    assign fifo_push  = bus.wr_valid && wr_ready && !bus.start;
    assign fifo_pop   = (state_q == ST_FEED) && !fifo_empty && !final_held &&
                        (!k_in_ready_q || xfer) && !bus.start;
    assign fifo_flush = bus.start || (state_q == ST_CLR);
    assign wr_entry   = '{last: bus.wr_last, bytes: bus.wr_bytes, data: bus.wr_data};

    sha3_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FIFO_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .wdata_i (wr_entry),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            clr_cnt_q    <= '0;
            k_reset_q    <= 1'b1;
            k_in_q       <= '0;
            k_in_ready_q <= 1'b0;
            k_is_last_q  <= 1'b0;
            k_byte_num_q <= '0;
            pad_pend_q   <= 1'b0;
            last_acc_q   <= 1'b0;
            done_q       <= 1'b0;
            out_size_q   <= SIZE_512;
            digest_q     <= '0;
        end else if (bus.start) begin
            // start overrides everything, including a transfer completing this cycle.
            state_q      <= ST_CLR;
            clr_cnt_q    <= '0;
            k_reset_q    <= 1'b1;
            out_size_q   <= out_size_e'(bus.out_size_in);
            k_in_ready_q <= 1'b0;
            k_is_last_q  <= 1'b0;
            k_byte_num_q <= '0;
            pad_pend_q   <= 1'b0;
            last_acc_q   <= 1'b0;
            done_q       <= 1'b0;
            digest_q     <= '0;
        end else begin
            if (fifo_push && bus.wr_last) last_acc_q <= 1'b1;
            case (state_q)
                ST_CLR: begin
                    if (clr_cnt_q == CNT_W'(CLR_CYCLES - 1)) begin
                        k_reset_q <= 1'b0;
                        state_q   <= ST_FEED;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + CNT_W'(1);
                    end
                end
                ST_FEED: begin
                    if (xfer && k_is_last_q) begin
                        k_in_ready_q <= 1'b0;
                        state_q      <= ST_WAIT;
                    end else if (xfer && pad_pend_q) begin
                        k_in_q       <= '0;
                        k_is_last_q  <= 1'b1;
                        k_byte_num_q <= '0;
                        pad_pend_q   <= 1'b0;
                        state_q      <= ST_PAD;
                    end else if (fifo_pop) begin
                        k_in_q       <= head.data;
                        k_in_ready_q <= 1'b1;
                        k_is_last_q  <= head.last && !head.bytes[2];
                        k_byte_num_q <= (head.last && !head.bytes[2]) ? head.bytes[1:0] : 2'd0;
                        pad_pend_q   <= head.last && head.bytes[2];
                    end else if (xfer) begin
                        k_in_ready_q <= 1'b0;
                    end
                end
                ST_PAD: begin
                    if (xfer) begin
                        k_in_ready_q <= 1'b0;
                        state_q      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.k_out_ready) begin
                        digest_q <= bus.k_out;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_IDLE, ST_DONE: ;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign digest_view    = digest_q;
    assign bus.wr_ready   = wr_ready;
    assign bus.k_reset    = k_reset_q;
    assign bus.k_in       = k_in_q;
    assign bus.k_in_ready = k_in_ready_q;
    assign bus.k_is_last  = k_is_last_q;
    assign bus.k_byte_num = k_byte_num_q;
    assign bus.k_out_size = out_size_q;
    assign bus.done       = done_q;
    assign bus.busy       = state_q inside {ST_CLR, ST_FEED, ST_PAD, ST_WAIT};
    // Word 0 is the most significant word; indices past the digest length read 0.
    assign bus.rd_data    = ({1'b0, bus.rd_idx} < digest_words(out_size_q)) ?
                            digest_view[4'd15 - bus.rd_idx] : 32'd0;
endmodule

// File: tb/tb_sha3_feeder.sv
// Directed bench for sha3_feeder: a scoreboard of expected core transfers is
// built from accepted writes and compared against every completed transfer.
module tb_sha3_feeder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sha3_feeder_if bus();
    sha3_feeder #(.FIFO_DEPTH(4), .CLR_CYCLES(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    localparam logic [255:0] D_EMPTY = 256'ha7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a;
    localparam logic [255:0] D_ABC   = 256'h3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532;
    localparam logic [255:0] JUNK    = {8{32'hdeadbeef}};

    typedef struct { logic [31:0] data; logic last; logic [1:0] bn; } xfer_t;

    int    n_checks = 0;
    int    n_errors = 0;
    xfer_t exp_q[$];
    xfer_t log_q[$];
    bit    last_sent = 0;
    bit    stall_prev = 0;
    xfer_t held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [511:0] dg, input logic [1:0] sz, input int i);
        int n;
        n = (sz == 2'd0) ? 16 : (sz == 2'd1) ? 12 : (sz == 2'd2) ? 8 : 7;
        return (i < n) ? dg[511 - 32*i -: 32] : 32'd0;
    endfunction

    // Scoreboard / compare process, sampled on the falling edge.
    always @(negedge clk) begin
        xfer_t cur, e;
        if (reset || bus.start) begin
            exp_q.delete();
            last_sent  = 0;
            stall_prev = 0;
        end else begin
            cur = '{bus.k_in, bus.k_is_last, bus.k_byte_num};
            if (stall_prev) begin
                check("hold_valid", bus.k_in_ready, 1);
                check("hold_word", {cur.data, cur.last, cur.bn}, {held.data, held.last, held.bn});
            end
            if (last_sent) check("no_valid_after_last", bus.k_in_ready, 0);
            if (bus.k_in_ready && !bus.k_buffer_full) begin
                log_q.push_back(cur);
                check("xfer_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("xfer_word", {cur.data, cur.last, cur.bn}, {e.data, e.last, e.bn});
                end
                if (bus.k_is_last) last_sent = 1;
            end
            stall_prev = bus.k_in_ready && bus.k_buffer_full;
            held = cur;
            if (bus.wr_valid && bus.wr_ready) begin
                if (!bus.wr_last) exp_q.push_back('{bus.wr_data, 1'b0, 2'd0});
                else if (bus.wr_bytes >= 3'd4) begin
                    exp_q.push_back('{bus.wr_data, 1'b0, 2'd0});
                    exp_q.push_back('{32'd0, 1'b1, 2'd0});
                end else exp_q.push_back('{bus.wr_data, 1'b1, bus.wr_bytes[1:0]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] sz);
        bus.start = 1'b1;
        bus.out_size_in = sz;
        tick();
        bus.start = 1'b0;
        log_q.delete();
    endtask

    task automatic send_word(input logic [31:0] d, input bit last, input logic [2:0] nb);
        bit acc = 0;
        bus.wr_valid = 1'b1; bus.wr_data = d; bus.wr_last = last; bus.wr_bytes = nb;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = bus.wr_ready;
            tick();
        end
        if (!acc) check("wr_accept_timeout", bus.wr_ready, 1);
        bus.wr_valid = 1'b0;
    endtask

    task automatic core_respond(input logic [511:0] dg);
        for (int i = 0; i < 200 && !last_sent; i++) tick();
        check("last_sent_seen", last_sent, 1);
        repeat (3) tick();
        @(negedge clk);
        check("busy_in_wait", bus.busy, 1);
        check("done_low_in_wait", bus.done, 0);
        bus.k_out = dg;
        bus.k_out_ready = 1'b1;
        tick();
        bus.k_out_ready = 1'b0;
        bus.k_out = '1;
        @(negedge clk);
        check("done_set", bus.done, 1);
        check("busy_clear_done", bus.busy, 0);
    endtask

    task automatic check_digest(input logic [511:0] dg, input logic [1:0] sz);
        for (int i = 0; i < 16; i++) begin
            bus.rd_idx = i[3:0];
            #1;
            check($sformatf("rd_word%0d", i), bus.rd_data, exp_word(dg, sz, i));
        end
    endtask

    task automatic rd_lit(input logic [3:0] idx, input logic [31:0] v);
        bus.rd_idx = idx;
        #1;
        check($sformatf("rd_lit%0d", idx), bus.rd_data, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, kr;
        logic [31:0] nxt;
        reset = 1'b1;
        bus.start = 0; bus.out_size_in = 0; bus.wr_valid = 0; bus.wr_data = 0; bus.wr_last = 0;
        bus.wr_bytes = 0; bus.k_buffer_full = 0; bus.k_out = '0; bus.k_out_ready = 0; bus.rd_idx = 0;

        // Reset values
        @(negedge clk);
        check("rst_wr_ready", bus.wr_ready, 0);
        check("rst_k_reset", bus.k_reset, 1);
        check("rst_k_in_ready", bus.k_in_ready, 0);
        check("rst_k_is_last", bus.k_is_last, 0);
        check("rst_k_in", bus.k_in, 0);
        check("rst_k_byte_num", bus.k_byte_num, 0);
        check("rst_k_out_size", bus.k_out_size, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_rd_data", bus.rd_data, 0);
        reset = 1'b0;

        // IDLE ignores writes
        bus.wr_valid = 1'b1; bus.wr_data = 32'h11223344;
        repeat (3) begin
          @(negedge clk);
          check("idle_wr_ready", bus.wr_ready, 0);
          check("idle_k_reset", bus.k_reset, 1);
        end
        bus.wr_valid = 1'b0;
        tick();

        // Empty message, SHA3-256
        do_start(2'd2);
        @(negedge clk);
        check("out_size_latched", bus.k_out_size, 2);
        tick();
        send_word(32'h0, 1, 3'd0);
        core_respond({D_EMPTY, JUNK});
        check("empty_xfers", log_q.size(), 1);
        check("empty_x0", {log_q[0].data, log_q[0].last, log_q[0].bn}, {32'h0, 1'b1, 2'd0});
        check_digest({D_EMPTY, JUNK}, 2'd2);
        rd_lit(4'd0, 32'ha7ffc6f8);
        rd_lit(4'd7, 32'h80f8434a);

        // "abc", SHA3-256
        do_start(2'd2);
        send_word(32'h61626300, 1, 3'd3);
        core_respond({D_ABC, JUNK});
        check("abc_xfers", log_q.size(), 1);
        check("abc_x0", {log_q[0].data, log_q[0].last, log_q[0].bn}, {32'h61626300, 1'b1, 2'd3});
        check_digest({D_ABC, JUNK}, 2'd2);
        rd_lit(4'd0, 32'h3a985da7);
        rd_lit(4'd7, 32'h11431532);
        rd_lit(4'd8, 32'h0);

        // "abcd" needs the trailing empty word; SHA3-512 reads all 16 words
        do_start(2'd0);
        send_word(32'h61626364, 1, 3'd4);
        core_respond({D_ABC, D_EMPTY});
        check("abcd_xfers", log_q.size(), 2);
        check("abcd_x0", {log_q[0].data, log_q[0].last, log_q[0].bn}, {32'h61626364, 1'b0, 2'd0});
        check("abcd_x1", {log_q[1].data, log_q[1].last, log_q[1].bn}, {32'h0, 1'b1, 2'd0});
        check_digest({D_ABC, D_EMPTY}, 2'd0);
        rd_lit(4'd15, 32'h80f8434a);

        // Back-pressure mid-stream, SHA3-384
        do_start(2'd1);
        send_word(32'hA0000000, 0, 3'd0);
        repeat (3) tick();
        bus.k_buffer_full = 1'b1;
        send_word(32'hA0000001, 0, 3'd0);
        acc = 0;
        nxt = 32'hA0000002;
        bus.wr_valid = 1'b1; bus.wr_data = nxt; bus.wr_last = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.wr_ready) begin acc++; nxt++; end
            tick();
            bus.wr_data = nxt;
        end
        bus.wr_valid = 1'b0;
        @(negedge clk);
        check("stall_accepts", acc, 4);
        check("stall_wr_ready_low", bus.wr_ready, 0);
        tick();
        bus.k_buffer_full = 1'b0;
        send_word(32'hA0000006, 0, 3'd0);
        send_word(32'hA0000007, 1, 3'd2);
        core_respond({D_EMPTY, D_ABC});
        check("bp_xfers", log_q.size(), 8);
        check("bp_last", {log_q[7].data, log_q[7].last, log_q[7].bn}, {32'hA0000007, 1'b1, 2'd2});
        check_digest({D_EMPTY, D_ABC}, 2'd1);

        // Abort mid-FEED with 3 words queued
        do_start(2'd2);
        bus.k_buffer_full = 1'b1;
        for (int w = 0; w < 4; w++) send_word(32'hB0000000 + w, 0, 3'd0);
        tick();
        do_start(2'd2);
        kr = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.k_reset) kr++;
            check("abort_no_stale_valid", bus.k_in_ready, 0);
        end
        check("abort_k_reset_cycles", kr, 2);
        bus.k_buffer_full = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort_fifo_empty", bus.k_in_ready, 0);
        end
        check("abort_wr_ready", bus.wr_ready, 1);
        tick();
        send_word(32'h61626300, 1, 3'd3);
        core_respond({D_ABC, JUNK});
        check("abort_abc_xfers", log_q.size(), 1);
        rd_lit(4'd0, 32'h3a985da7);
        rd_lit(4'd7, 32'h11431532);

        // Asynchronous reset while DONE clears the digest
        #2 reset = 1'b1;
        #1;
        check("rst_done_done", bus.done, 0);
        rd_lit(4'd0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Asynchronous reset mid-WAIT
        do_start(2'd2);
        send_word(32'h61626300, 1, 3'd3);
        for (int i = 0; i < 200 && !last_sent; i++) tick();
        tick();
        @(negedge clk);
        check("wait_busy", bus.busy, 1);
        tick();
        #2 reset = 1'b1;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_k_in_ready", bus.k_in_ready, 0);
        check("arst_k_reset", bus.k_reset, 1);
        check("arst_wr_ready", bus.wr_ready, 0);
        for (int i = 0; i < 16; i++) begin
            bus.rd_idx = i[3:0];
            #1;
            check($sformatf("arst_rd%0d", i), bus.rd_data, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_k_reset", bus.k_reset, 1);
            check("post_rst_busy", bus.busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sha3_feeder.md
Name: sha3_feeder

Overview:
- Upstream sequencer for the keccak core in the SHA-3 accelerator.
- Accepts a byte-packed message stream from the peripheral bus side, buffers it in a small FIFO, and drives the keccak input handshake (in, in_ready, is_last, byte_num) while respecting buffer_full.
- Inserts the terminating empty word when the message is a multiple of 4 bytes.
- Clears the core between messages, latches the digest on out_ready, and serves it as 32-bit words.

Parameters:
- FIFO_DEPTH, 4, input FIFO entries; must be a power of 2 and at least 2.
- CLR_CYCLES, 2, number of cycles k_reset is held high per start.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: abort any job, clear the core, begin a new message
- out_size_in  in  2  0=512, 1=384, 2=256, 3=224; latched on start
- wr_valid  in  1  message word valid
- wr_ready  out  1  feeder can accept a word
- wr_data  in  32  message bytes; first byte in [31:24]
- wr_last  in  1  final word of the message
- wr_bytes  in  3  valid bytes in the final word, 0..4; ignored when wr_last=0
- k_reset  out  1  synchronous clear to the keccak core
- k_in  out  32  word to the core
- k_in_ready  out  1  word valid to the core
- k_is_last  out  1  final word to the core
- k_byte_num  out  2  valid bytes in the final word
- k_out_size  out  2  latched out_size
- k_buffer_full  in  1  core back-pressure
- k_out  in  512  core digest
- k_out_ready  in  1  core digest valid
- busy  out  1  high in states CLR, FEED, PAD and WAIT
- done  out  1  digest latched and valid
- rd_idx  in  4  digest word index
- rd_data  out  32  digest word (combinational)

Behaviour:
- Reset values: wr_ready=0, k_reset=1, k_in_ready=0, k_is_last=0, k_in=0, k_byte_num=0, k_out_size=0, busy=0, done=0, digest register=0, FIFO empty, state=IDLE.
- A core transfer completes in any cycle where k_in_ready=1 and k_buffer_full=0. k_in, k_is_last and k_byte_num are registered and held stable until the transfer completes.
- k_in_ready is never asserted after the is_last transfer of a job.
- State IDLE:
  - wr_ready=0 and wr_valid is ignored.
  - start goes to CLR.
- State CLR:
  - k_reset=1 for CLR_CYCLES cycles; out_size is latched; the FIFO is flushed; done and the digest are cleared.
  - Then goes to FEED.
- State FEED:
  - wr_ready = !fifo_full && !last_accepted.
  - The FIFO head is presented to the core.
  - A non-last word is sent with k_is_last=0.
  - A last word with wr_bytes 0..3 is sent with k_is_last=1 and k_byte_num=wr_bytes, then goes to WAIT.
  - A last word with wr_bytes=4 is sent as a full word (k_is_last=0), then goes to PAD.
- State PAD:
  - Presents k_in=0, k_is_last=1, k_byte_num=0.
  - On transfer, goes to WAIT.
- State WAIT:
  - On the first cycle with k_out_ready=1, latch k_out, set done=1, go to DONE.
- State DONE:
  - done is held at 1.
  - start goes to CLR and clears done.
- start in any state, including mid-FEED, aborts the job: FIFO flushed, pending core word dropped, go to CLR. start has priority over a simultaneous write or transfer.
- A simultaneous FIFO push and pop when full is not allowed, because wr_ready is low. A push and pop when empty-then-one is legal, with 1-cycle fall-through latency minimum from accepted wr to k_in_ready.
- rd_data = digest[511-32*rd_idx -: 32], so word 0 holds the first digest bytes.
- Indices at or beyond the digest length return 0. Digest length in words: 16 for 512, 12 for 384, 8 for 256, 7 for 224.
- Asynchronous reset mid-job returns to IDLE with all reset values; k_reset=1 during and after reset until the first CLR completes.

Decomposition:
- Shared package sha3_pkg holds:
  - out_size encodings;
  - digest word counts per size;
  - state enum IDLE/CLR/FEED/PAD/WAIT/DONE.
- One sub-module, sha3_fifo: a synchronous FIFO of width 36 ({last, bytes[2:0], data}) and depth FIFO_DEPTH, with full and empty flags.

Test Plan:
- Empty message, SHA3-256: start, then one word with wr_last=1 and wr_bytes=0 → exactly one core transfer (is_last=1, byte_num=0); done rises; rd_data[0]=0xa7ffc6f8 and rd_data[7]=0x80f8434a.
- "abc", SHA3-256: word 0x61626300, wr_last=1, wr_bytes=3 → k_byte_num=3; rd_data[0]=0x3a985da7 and rd_data[7]=0x11431532; rd_idx=8 returns 0.
- 4-byte message "abcd" with wr_bytes=4 → two core transfers (0x61626364 with is_last=0, then 0x00000000 with is_last=1 and byte_num=0); state passes through PAD.
- Back-pressure: hold k_buffer_full=1 for 20 cycles mid-stream → k_in stays stable; wr_ready drops after FIFO_DEPTH words are accepted; no word is lost or duplicated (order checked by scoreboard).
- Abort: assert start while in FEED with 3 words queued → k_reset is high for 2 cycles; FIFO is empty; a subsequent "abc" job yields the correct digest.
- Asynchronous reset asserted mid-WAIT → within the same cycle busy=0, done=0 and k_in_ready=0; rd_data=0 for all indices.
